// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter sharing one data_mem port, one transaction in flight at a time.
// Optional build macro: DATA_MEM_ARB_FIXED_PRIO_EN (port 0 always wins ties).
module data_mem_arbiter #(
    parameter int addr_width_p = 32,
    // mem_in_s  = {valid, wen, byte_not_word, write_data[31:0], yumi}
    // mem_out_s = {valid, read_data[31:0], yumi}
    localparam int MemInW  = 36,
    localparam int MemOutW = 34
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [MemInW-1:0]       req0_flat_i,
    input  logic [addr_width_p-1:0] req0_addr_i,
    output logic [MemOutW-1:0]      req0_flat_o,
    input  logic [MemInW-1:0]       req1_flat_i,
    input  logic [addr_width_p-1:0] req1_addr_i,
    output logic [MemOutW-1:0]      req1_flat_o,
    output logic [MemInW-1:0]       mem_flat_o,
    output logic [addr_width_p-1:0] mem_addr_o,
    input  logic [MemOutW-1:0]      mem_flat_i,
    output logic [1:0]              grant_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_owner, r_last;
    logic [addr_width_p-1:0] r_addr;
    logic                    r_wen, r_bnw;
    logic [31:0]             r_wdata, r_rdata;

    logic w_v0, w_v1, w_pick, w_accept, w_resp, w_owner_yumi, w_mem_valid, w_mem_yumi;
    logic w_unused_mem_yumi;

    assign w_v0              = req0_flat_i[35];
    assign w_v1              = req1_flat_i[35];
    assign w_mem_valid       = mem_flat_i[33];
    assign w_unused_mem_yumi = mem_flat_i[0];

    always_comb begin
        w_pick = 1'b0;
        if (w_v0 && w_v1) begin
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
            w_pick = 1'b0;
`else
            w_pick = ~r_last;
`endif
        end else if (w_v1) begin
            w_pick = 1'b1;
        end
    end

    assign w_accept     = (r_state == S_IDLE) && (w_v0 || w_v1);
    assign w_resp       = (r_state == S_RESP);
    assign w_mem_yumi   = (r_state == S_WAIT) && w_mem_valid;
    assign w_owner_yumi = r_owner ? req1_flat_i[0] : req0_flat_i[0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)     w_state_nxt = S_ISSUE;
            S_ISSUE: if (mem_flat_i[0] || 1'b0) w_state_nxt = r_state;
            default: w_state_nxt = r_state;
        endcase
        // memory yumi arrives on the response bus while in ISSUE
        if (r_state == S_ISSUE && mem_yumi_in()) w_state_nxt = S_WAIT;
        if (r_state == S_WAIT && w_mem_valid)    w_state_nxt = S_RESP;
        if (r_state == S_RESP && w_owner_yumi)   w_state_nxt = S_IDLE;
    end

    function automatic logic mem_yumi_in();
        return mem_flat_i[0];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_bnw   <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner <= w_pick;
                r_addr  <= w_pick ? req1_addr_i     : req0_addr_i;
                r_wen   <= w_pick ? req1_flat_i[34] : req0_flat_i[34];
                r_bnw   <= w_pick ? req1_flat_i[33] : req0_flat_i[33];
                r_wdata <= w_pick ? req1_flat_i[32:1] : req0_flat_i[32:1];
            end
            if (w_mem_yumi) begin
                r_rdata <= r_wen ? 32'h0 : mem_flat_i[32:1];
            end
            if (w_resp && w_owner_yumi) begin
                r_last <= r_owner;
            end
        end
    end

    // Everything toward a requester is gated by ownership so the other side only ever sees zeros.
    always_comb begin
        req0_flat_o = '0;
        req1_flat_o = '0;
        req0_flat_o[0] = w_accept && !w_pick;
        req1_flat_o[0] = w_accept && w_pick;
        if (w_resp && !r_owner) req0_flat_o[33:1] = {1'b1, r_rdata};
        if (w_resp && r_owner)  req1_flat_o[33:1] = {1'b1, r_rdata};
    end

    assign mem_flat_o = {(r_state == S_ISSUE), r_wen, r_bnw, r_wdata, w_mem_yumi};
    assign mem_addr_o = r_addr;
    assign busy_o     = (r_state != S_IDLE);
    assign grant_o    = busy_o ? (r_owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a zero-wait byte-addressed data_mem model.
// Build with DATA_MEM_ARB_FIXED_PRIO_EN to check fixed-priority expectations.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [35:0] req0_flat_i, req1_flat_i, mem_flat_o;
    logic [33:0] req0_flat_o, req1_flat_o, mem_flat_i;
    logic [31:0] req0_addr_i, req1_addr_i, mem_addr_o;
    logic [1:0]  grant_o;
    logic        busy_o;

    logic        r0_v = 0, r0_wen = 0, r0_bnw = 0, r0_y = 0;
    logic        r1_v = 0, r1_wen = 0, r1_bnw = 0, r1_y = 0;
    logic [31:0] r0_wd = 0, r1_wd = 0, r0_a = 0, r1_a = 0;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    assign req0_flat_i = {r0_v, r0_wen, r0_bnw, r0_wd, r0_y};
    assign req1_flat_i = {r1_v, r1_wen, r1_bnw, r1_wd, r1_y};
    assign req0_addr_i = r0_a;
    assign req1_addr_i = r1_a;

    data_mem_arbiter #(.addr_width_p(32)) dut (
        .clk(clk), .reset(rst_n),
        .req0_flat_i(req0_flat_i), .req0_addr_i(req0_addr_i), .req0_flat_o(req0_flat_o),
        .req1_flat_i(req1_flat_i), .req1_addr_i(req1_addr_i), .req1_flat_o(req1_flat_o),
        .mem_flat_o(mem_flat_o), .mem_addr_o(mem_addr_o), .mem_flat_i(mem_flat_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    // data_mem model: accepts immediately, responds the following cycle.
    logic [7:0]  mem_arr [0:255];
    logic        m_pend;
    logic [31:0] m_rdata;
    logic [7:0]  m_a;
    assign m_a        = mem_addr_o[7:0];
    assign mem_flat_i = {m_pend, m_rdata, mem_flat_o[35]};

    always_ff @(posedge clk) begin
        if (mem_flat_o[35] && mem_flat_o[34]) begin
            if (mem_flat_o[33]) begin
                mem_arr[m_a] <= mem_flat_o[8:1];
            end else begin
                mem_arr[m_a]         <= mem_flat_o[8:1];
                mem_arr[m_a + 8'd1]  <= mem_flat_o[16:9];
                mem_arr[m_a + 8'd2]  <= mem_flat_o[24:17];
                mem_arr[m_a + 8'd3]  <= mem_flat_o[32:25];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend  <= 1'b0;
            m_rdata <= '0;
        end else if (mem_flat_o[35]) begin
            m_pend <= 1'b1;
            if (mem_flat_o[34])      m_rdata <= 32'hFFFF_FFFF;
            else if (mem_flat_o[33]) m_rdata <= {24'h0, mem_arr[m_a]};
            else m_rdata <= {mem_arr[m_a + 8'd3], mem_arr[m_a + 8'd2], mem_arr[m_a + 8'd1], mem_arr[m_a]};
        end else if (m_pend && mem_flat_o[0]) begin
            m_pend <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic set_req(input logic p, input logic v, input logic wen, input logic bnw,
                           input logic [31:0] a, input logic [31:0] wd);
        if (!p) begin r0_v = v; r0_wen = wen; r0_bnw = bnw; r0_a = a; r0_wd = wd; end
        else    begin r1_v = v; r1_wen = wen; r1_bnw = bnw; r1_a = a; r1_wd = wd; end
    endtask

    task automatic set_yumi(input logic p, input logic y);
        if (!p) r0_y = y; else r1_y = y;
    endtask

    function automatic logic [33:0] pout(input logic p);
        return p ? req1_flat_o : req0_flat_o;
    endfunction

    task automatic txn(input string nm, input logic p, input logic wen, input logic bnw,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp);
        set_req(p, 1'b1, wen, bnw, a, wd);
        #1;
        chk({nm, "_yumi"}, 64'(pout(p)[0]), 64'd1);
        chk({nm, "_idle_busy"}, 64'(busy_o), 64'd0);
        @(posedge clk); #1;
        set_req(p, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk({nm, "_grant"}, 64'(grant_o), p ? 64'd2 : 64'd1);
        chk({nm, "_mem_req"}, {mem_flat_o[35:1], mem_addr_o}, {1'b1, wen, bnw, wd, a});
        @(posedge clk); #2;
        chk({nm, "_mem_wait"}, {62'(0), mem_flat_o[35], mem_flat_o[0]}, 64'd1);
        @(posedge clk); #2;
        chk({nm, "_resp"}, 64'(pout(p)), 64'({1'b1, exp, 1'b0}));
        chk({nm, "_other_zero"}, 64'(pout(~p)), 64'd0);
        set_yumi(p, 1'b1);
        @(posedge clk); #1;
        set_yumi(p, 1'b0);
        #1;
        chk({nm, "_done"}, {61'(0), busy_o, grant_o}, 64'd0);
    endtask

    typedef struct {
        logic        p, wen, bnw;
        logic [31:0] a, wd, exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int rounds, acc, last_cyc;
        logic exp_p;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h20, 32'h1122_3344, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h21, 32'h0000_00A5, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h21, 32'h0,         32'h0000_00A5};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h20, 32'h0,         32'h1122_A544};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h30, 32'h1234_5678, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h31, 32'h0,         32'h0000_0056};

        #12;
        chk("rst_req0", 64'(req0_flat_o), 64'd0);
        chk("rst_req1", 64'(req1_flat_o), 64'd0);
        chk("rst_mem", 64'(mem_flat_o), 64'd0);
        chk("rst_grant_busy", {61'(0), busy_o, grant_o}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            txn($sformatf("v%0d", i), vecs[i].p, vecs[i].wen, vecs[i].bnw,
                vecs[i].a, vecs[i].wd, vecs[i].exp);

        // asynchronous reset while the request sits in ISSUE
        set_req(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("midrst_issue", 64'(mem_flat_o[35]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem", 64'(mem_flat_o), 64'd0);
        chk("midrst_req1", 64'(req1_flat_o), 64'd0);
        chk("midrst_grant_busy", {61'(0), busy_o, grant_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // both ports continuously requesting, starting from reset arbitration state
        set_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
        rounds = 0; acc = 0; last_cyc = -1;
        for (int cyc = 0; cyc < 40 && rounds < 4; cyc++) begin
            #1;
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
            exp_p = 1'b0;
`else
            exp_p = acc[0];
`endif
            if (req0_flat_o[0]) begin chk("rr_order", 64'd0, 64'(exp_p)); acc++; end
            if (req1_flat_o[0]) begin chk("rr_order", 64'd1, 64'(exp_p)); acc++; end
            if (req0_flat_o[33]) begin
                chk("rr_data0", 64'(req0_flat_o), 64'({1'b1, 32'hDEAD_BEEF, 1'b0}));
                chk("rr_iso1", 64'(req1_flat_o), 64'd0);
                r0_y = 1'b1; rounds++; last_cyc = cyc;
            end
            if (req1_flat_o[33]) begin
                chk("rr_data1", 64'(req1_flat_o), 64'({1'b1, 32'h1234_5678, 1'b0}));
                chk("rr_iso0", 64'(req0_flat_o), 64'd0);
                r1_y = 1'b1; rounds++; last_cyc = cyc;
            end
            @(posedge clk); #1;
            r0_y = 1'b0; r1_y = 1'b0;
        end
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rr_rounds", 64'(rounds), 64'd4);
        chk("rr_rate", 64'(last_cyc), 64'd15);
        #1;
        chk("rr_idle", 64'(busy_o), 64'd0);
        @(posedge clk); #1;

        // owner stalls yumi in RESP while port 1 waits
        set_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        #1;
        chk("stall_acc", 64'(req0_flat_o[0]), 64'd1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        set_req(1'b1, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall_hold%0d", k), 64'(req0_flat_o), 64'({1'b1, 32'hDEAD_BEEF, 1'b0}));
            chk($sformatf("stall_noyumi%0d", k), 64'(req1_flat_o), 64'd0);
            @(posedge clk); #1;
        end
        set_yumi(1'b0, 1'b1);
        #1;
        chk("stall_resp_noyumi", 64'(req1_flat_o[0]), 64'd0);
        @(posedge clk); #1;
        set_yumi(1'b0, 1'b0);
        #1;
        chk("stall_p1_acc", {62'(0), req1_flat_o[0], busy_o}, 64'd2);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(posedge clk); #2;
        chk("stall_p1_resp", 64'(req1_flat_o), 64'({1'b1, 32'h1234_5678, 1'b0}));
        chk("stall_p0_zero", 64'(req0_flat_o), 64'd0);
        set_yumi(1'b1, 1'b1);
        @(posedge clk); #1;
        set_yumi(1'b1, 1'b0);
        #1;
        chk("stall_done", 64'(busy_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter that shares one `data_mem` port between two masters (core load/store unit and a secondary requester such as a DMA or debug port). It speaks the `mem_in_s`/`mem_out_s` valid/yumi handshake on every side, so each requester sees an ordinary memory and the memory sees a single core. One transaction is outstanding at a time. Request fields are registered, and the response is buffered until the owning requester accepts it.

## Interface
- `addr_width_p`, 32 — width of the requester and memory address buses.
- `clk`  in  1  — single clock, posedge.
- `reset`  in  1  — asynchronous, active-low; `reset==0` clears all state.
- `req0_flat_i`  in  `$bits(mem_in_s)`  — requester 0 request (valid, wen, byte_not_word, write_data, yumi).
- `req0_addr_i`  in  `addr_width_p`  — requester 0 byte address.
- `req0_flat_o`  out  `$bits(mem_out_s)`  — requester 0 response (valid, read_data, yumi).
- `req1_flat_i`, `req1_addr_i`, `req1_flat_o`  — same as port 0, for requester 1.
- `mem_flat_o`  out  `$bits(mem_in_s)`  — request to `data_mem`.
- `mem_addr_o`  out  `addr_width_p`  — address to `data_mem`.
- `mem_flat_i`  in  `$bits(mem_out_s)`  — response from `data_mem`.
- `grant_o`  out  2  — one-hot current owner; 0 when IDLE.
- `busy_o`  out  1  — state != IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Registers: `owner_r`, `last_r`, `addr_r`, `wen_r`, `bnw_r`, `wdata_r`, `rdata_r`.
- IDLE:
  - If only one `reqN.valid` is high, N wins.
  - If both are high, the winner is the port != `last_r` (round-robin).
  - The winner's `reqN_flat_o.yumi` is driven combinationally high in this cycle. The loser's yumi stays 0, and the loser must hold its request.
  - The winner's fields are latched and the state moves to ISSUE.
- ISSUE:
  - `mem.valid=1`; wen, byte_not_word, write_data and addr come from the latched registers.
  - On `mem_flat_i.yumi=1`, go to WAIT. Otherwise hold ISSUE; there is no timeout.
- WAIT:
  - `mem.valid=0`.
  - On `mem_flat_i.valid=1`: drive `mem.yumi=1` in the same cycle, capture `rdata_r` (forced to 0 when `wen_r`), and go to RESP.
- RESP:
  - `reqN_flat_o.valid=1` and `read_data=rdata_r` to the owner only.
  - On owner `yumi=1`: `last_r<=owner`, go to IDLE.
  - New requests are not examined until IDLE.
- Non-owner outputs are always 0: valid, yumi, read_data.
- Requester yumi is ignored outside RESP. Memory valid is ignored outside WAIT.
- Byte/word semantics and out-of-range address handling belong to `data_mem`; the arbiter passes these through unchanged.

## Timing
- Reset (async assert):
  - state=IDLE, `last_r`=1 (port 0 wins the first tie).
  - All outputs 0: `mem.valid`, `mem.yumi`, both `reqN.valid/yumi/read_data`, `grant_o`, `busy_o`.
  - Data registers are cleared to 0.
- Reset mid-transaction aborts without a response. `data_mem` shares the reset net, so it returns to IDLE at the same time.
- Minimum latency with zero-wait `data_mem`:
  - Accept (yumi) at cycle 0.
  - ISSUE and mem yumi at cycle 1.
  - Mem valid seen in WAIT at cycle 2.
  - `reqN.valid` at cycle 3.
  - Owner yumi at cycle 3 gives IDLE at cycle 4.
- Minimum issue rate: one transaction per 4 cycles.
- Back-to-back under contention alternates 0,1,0,1.
- A single active requester is served repeatedly with no penalty.
- Simultaneous events:
  - A new request arriving while RESP completes is examined the cycle after the return to IDLE.
  - Both requests arriving at once follow the round-robin rule.
- `grant_o` and `busy_o` are registered state decodes, valid from the cycle after acceptance until the return to IDLE.

## Configuration
- `DATA_MEM_ARB_FIXED_PRIO_EN`:
  - Defined: port 0 always wins when both are valid. `last_r` is still updated but unused for selection. Port 1 can starve.
  - Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then idle: all outputs 0, `busy_o=0`. Assert `reset=0` mid-ISSUE: outputs return to 0 asynchronously, before the next clk edge.
- Port 0 word write 0xDEADBEEF to 0x10, then port 0 word read of 0x10 -> `req0.valid` at cycle 3 with `read_data=0xDEADBEEF`. The write response has `read_data=0`.
- Both ports request reads on the same cycle, 4 rounds (default build) -> grant order 0,1,0,1; each port receives only its own data.
- Same stimulus with `DATA_MEM_ARB_FIXED_PRIO_EN` defined and port 0 held continuously valid -> port 1 is never granted while port 0 is valid.
- Owner delays yumi by 5 cycles in RESP -> `valid` and `read_data` stay stable for those 5 cycles. A port 1 request made meanwhile gets no yumi until IDLE, then is granted.
- Port 1 byte write 0xA5 to 0x21, then port 0 byte read of 0x21 -> `read_data=0x000000A5` on port 0; port 1 outputs stay 0.
